// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Run/debug sequencer for the single-cycle core: core reset,
//             commit gating, run/step/breakpoint/halt-opcode, retire count.
//  Revision : 1.0
// ============================================================================
module cpu_run_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter int         STEP_W     = 16,
  parameter int         RST_CYCLES = 4,
  parameter logic [5:0] HALT_OP    = 6'h3F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [31:0]       cmd_data,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       inst,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic [1:0]        state,
  output logic [2:0]        halt_cause,
  output logic              bp_en,
  output logic [31:0]       retired
);

  localparam logic [1:0] c_ST_CORE_RST = 2'd0;
  localparam logic [1:0] c_ST_HALTED   = 2'd1;
  localparam logic [1:0] c_ST_RUN      = 2'd2;
  localparam logic [1:0] c_ST_STEP     = 2'd3;

  localparam logic [2:0] c_OP_RUN        = 3'd1;
  localparam logic [2:0] c_OP_HALT       = 3'd2;
  localparam logic [2:0] c_OP_STEP       = 3'd3;
  localparam logic [2:0] c_OP_SET_BP     = 3'd4;
  localparam logic [2:0] c_OP_CLR_BP     = 3'd5;
  localparam logic [2:0] c_OP_CLR_CNT    = 3'd6;
  localparam logic [2:0] c_OP_RESET_CORE = 3'd7;

  localparam logic [2:0] c_CAUSE_RESET     = 3'd0;
  localparam logic [2:0] c_CAUSE_HOST      = 3'd1;
  localparam logic [2:0] c_CAUSE_STEP_DONE = 3'd2;
  localparam logic [2:0] c_CAUSE_BP        = 3'd3;
  localparam logic [2:0] c_CAUSE_HALT_INST = 3'd4;

  localparam int                c_RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_RC_W-1:0] r_rst_cnt;
  logic [2:0]        r_halt_cause;
  logic              r_bp_en;
  logic [ADDR_W-1:0] r_bp_addr;
  logic [31:0]       r_retired;
  logic [STEP_W-1:0] r_steps_left;
  logic              r_skip;

  logic              w_cmd_acc;
  logic              w_host_halt;
  logic              w_host_rst;
  logic              w_active;
  logic              w_halt_hit;
  logic              w_bp_hit;
  logic              w_rst_done;
  logic              w_step_last;
  logic [STEP_W-1:0] w_step_n;
  logic              w_unused;

  assign w_cmd_acc   = cmd_valid && cmd_ready;
  assign w_host_halt = w_cmd_acc && (cmd_op == c_OP_HALT);
  assign w_host_rst  = w_cmd_acc && (cmd_op == c_OP_RESET_CORE);
  assign w_active    = (r_state == c_ST_RUN) || (r_state == c_ST_STEP);
  assign w_halt_hit  = (inst[31:26] == HALT_OP);
  // skip masks the breakpoint for the first cycle after a resume
  assign w_bp_hit    = r_bp_en && (pc == r_bp_addr) && !r_skip;
  assign w_rst_done  = (r_rst_cnt == c_RST_LAST);
  assign w_step_last = (r_state == c_ST_STEP) && (r_steps_left == STEP_W'(1));
  assign w_step_n    = cmd_data[STEP_W-1:0];
  assign w_unused    = ^inst[25:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_CORE_RST;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic; host HALT/RESET_CORE outrank core-side events
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CORE_RST: begin
        if (w_rst_done) w_state_nxt = c_ST_HALTED;
      end
      c_ST_HALTED: begin
        if (w_host_rst)                                          w_state_nxt = c_ST_CORE_RST;
        else if (w_cmd_acc && cmd_op == c_OP_RUN)                w_state_nxt = c_ST_RUN;
        else if (w_cmd_acc && cmd_op == c_OP_STEP && |w_step_n)  w_state_nxt = c_ST_STEP;
      end
      c_ST_RUN, c_ST_STEP: begin
        if (w_host_rst)                                  w_state_nxt = c_ST_CORE_RST;
        else if (w_host_halt || w_halt_hit || w_bp_hit)  w_state_nxt = c_ST_HALTED;
        else if (w_step_last)                            w_state_nxt = c_ST_HALTED;
      end
      default: w_state_nxt = c_ST_CORE_RST;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpu_rst   = (r_state == c_ST_CORE_RST);
    cmd_ready = (r_state != c_ST_CORE_RST);
    cpu_en    = w_active && !w_halt_hit && !w_bp_hit && !w_host_halt && !w_host_rst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rst_cnt    <= '0;
      r_halt_cause <= c_CAUSE_RESET;
      r_bp_en      <= 1'b0;
      r_bp_addr    <= '0;
      r_retired    <= '0;
      r_steps_left <= '0;
      r_skip       <= 1'b0;
    end else begin
      if (r_state == c_ST_CORE_RST && !w_rst_done) r_rst_cnt <= r_rst_cnt + c_RC_W'(1);
      else                                         r_rst_cnt <= '0;

      // a core reset leaves the cause alone until the sequence completes
      if (r_state == c_ST_CORE_RST && w_rst_done) begin
        r_halt_cause <= c_CAUSE_RESET;
      end else if (w_active && !w_host_rst) begin
        if (w_host_halt)      r_halt_cause <= c_CAUSE_HOST;
        else if (w_halt_hit)  r_halt_cause <= c_CAUSE_HALT_INST;
        else if (w_bp_hit)    r_halt_cause <= c_CAUSE_BP;
        else if (w_step_last) r_halt_cause <= c_CAUSE_STEP_DONE;
      end

      if (r_state == c_ST_HALTED) r_skip <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_STEP);
      else                        r_skip <= 1'b0;

      if (r_state == c_ST_HALTED && w_state_nxt == c_ST_STEP) r_steps_left <= w_step_n;
      else if (r_state == c_ST_STEP && cpu_en)                r_steps_left <= r_steps_left - STEP_W'(1);

      if (w_cmd_acc && cmd_op == c_OP_SET_BP) begin
        r_bp_addr <= cmd_data[ADDR_W-1:0];
        r_bp_en   <= 1'b1;
      end else if (w_cmd_acc && cmd_op == c_OP_CLR_BP) begin
        r_bp_en   <= 1'b0;
      end

      if (w_cmd_acc && cmd_op == c_OP_CLR_CNT) r_retired <= '0;
      else if (cpu_en)                         r_retired <= r_retired + 32'd1;
    end
  end

  assign state      = r_state;
  assign halt_cause = r_halt_cause;
  assign bp_en      = r_bp_en;
  assign retired    = r_retired;

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the single-cycle core. It holds the core in reset, gates its commit enable, and supports free-running, N-instruction stepping, a single PC breakpoint and a halt opcode. It sits between the host/debug command interface and the core's PC register, register-file write, data-memory write and reset inputs, and counts retired instructions.

Parameters:
ADDR_W, 32, width of PC and breakpoint address
STEP_W, 16, width of step count, taken from cmd_data[STEP_W-1:0]
RST_CYCLES, 4, cycles cpu_rst is held per core-reset sequence (>=1)
HALT_OP, 6'h3F, opcode (inst[31:26]) that halts the core; it is never executed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts a command this cycle
cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 RESET_CORE
cmd_data  in  32  STEP count or breakpoint address
pc  in  ADDR_W  current core PC
inst  in  32  instruction at pc
cpu_en  out  1  core commits this edge (PC, RF write, mem write)
cpu_rst  out  1  core reset
state  out  2  0 CORE_RST, 1 HALTED, 2 RUN, 3 STEP
halt_cause  out  3  0 RESET, 1 HOST, 2 STEP_DONE, 3 BREAKPOINT, 4 HALT_INST
bp_en  out  1  breakpoint armed
retired  out  32  retired-instruction counter

Behaviour:
- Clock is clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=CORE_RST, rst_cnt=0, cpu_rst=1, cpu_en=0, halt_cause=0, bp_en=0, bp_addr=0, retired=0, steps_left=0, skip=0.
- Command handshake: a command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = (state != CORE_RST).
  - Every accepted command takes effect at the next edge. There is no backpressure beyond the CORE_RST state.
- cpu_rst = (state==CORE_RST). It is combinational from the state register.
- CORE_RST:
  - rst_cnt increments each cycle.
  - When rst_cnt==RST_CYCLES-1, go to HALTED with halt_cause=0 and rst_cnt cleared.
  - cpu_en=0 throughout.
- HALTED:
  - cpu_en=0.
  - RUN: go to RUN and set skip=1.
  - STEP with N=cmd_data[STEP_W-1:0]: if N!=0, go to STEP with steps_left=N and skip=1. If N==0, the command is accepted and has no effect.
  - HALT: no effect.
- Per-cycle definitions in RUN and STEP:
  - halt_hit = (inst[31:26]==HALT_OP).
  - bp_hit = bp_en && (pc==bp_addr) && !skip.
  - cpu_en = !halt_hit && !bp_hit.
  - skip clears after any cycle spent in RUN or STEP.
- RUN:
  - halt_hit → HALTED, cause 4.
  - Otherwise bp_hit → HALTED, cause 3. halt_hit has priority over bp_hit.
  - The instruction at the breakpoint PC is not committed.
  - Resuming with RUN or STEP commits it, because skip masks bp_hit in the first cycle.
- STEP:
  - halt_hit → cause 4; otherwise bp_hit → cause 3.
  - Otherwise commit and decrement steps_left. If steps_left==1 this cycle, go to HALTED with cause 2. Exactly N instructions commit.
- Commands while in RUN or STEP:
  - HALT → HALTED, cause 1. cpu_en is forced to 0 in the acceptance cycle.
  - RUN and STEP are accepted and ignored.
  - RESET_CORE is accepted in HALTED, RUN and STEP: go to CORE_RST with rst_cnt=0 and cpu_en=0 in the acceptance cycle. Breakpoint and counter are retained.
- Simultaneous events: a host HALT or RESET_CORE overrides halt_hit, bp_hit and step completion in the same cycle. The recorded cause is the host one (1 for HALT; 0 after the reset sequence).
- Breakpoint commands are valid in all non-CORE_RST states and take effect at the next edge.
  - SET_BP: bp_addr = cmd_data[ADDR_W-1:0], bp_en=1.
  - CLR_BP: bp_en=0.
- retired counter:
  - Increments on every edge where cpu_en=1.
  - Wraps from 32'hFFFFFFFF to 0.
  - CLR_CNT clears it. Clear beats increment in the same cycle (result 0).
- reset asserted in any state, mid-step or mid-reset-sequence, returns all registers to their reset values at the next edge.

Test Plan:
- Reset 1 cycle, RST_CYCLES=4 → cpu_rst=1 for exactly 4 cycles after reset release, then state=HALTED, cause=0, cmd_ready=1, retired=0.
- STEP N=3, no halt or breakpoint opcodes → cpu_en high for exactly 3 cycles, retired=3, state=HALTED, cause=2. STEP N=0 → no cpu_en pulse, state stays HALTED.
- SET_BP 0x10, RUN with pc ramping 0,1,2… → cpu_en=0 when pc=0x10, state=HALTED, cause=3, retired=16. A second RUN commits 0x10 (cpu_en=1 in the first cycle) and then continues.
- RUN, inst=0xFC000000 at pc=5 with bp also at 5 → cause=4 (halt opcode wins), no commit at pc 5. A later RUN immediately re-halts with cause 4 and retired unchanged.
- RUN, then HALT and RESET_CORE in consecutive cycles → HALT gives cause=1, cpu_en=0 on acceptance. RESET_CORE gives cpu_rst=1 for 4 cycles, with bp_en and retired preserved.
- retired preloaded to 0xFFFFFFFF via a running core, then one commit → 0. CLR_CNT in the same cycle as a commit → retired=0.
